// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_pkg
//  Purpose  : Shared constants, FSM encoding and frame-packing helpers for
//             the LFSR frame sequencer.
//  Config   : FRAME_CSUM_EN - adds a trailing XOR checksum byte per frame
//  Revision : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

   // Byte tags occupying the top three bits of each frame byte
   localparam logic [2:0] TAG_B0 = 3'b000;
   localparam logic [2:0] TAG_B1 = 3'b001;
   localparam logic [2:0] TAG_B2 = 3'b010;
   localparam logic [2:0] TAG_B3 = 3'b011;
   localparam logic [2:0] TAG_B4 = 3'b100;
   localparam logic [2:0] TAG_B5 = 3'b101;
   localparam logic [2:0] TAG_B6 = 3'b110;
   localparam logic [2:0] TAG_B7 = 3'b111;

   // LFSR value after reset, also used whenever a zero seed is requested
   localparam logic [31:0] RST_SEED = 32'h0000_0001;

`ifdef FRAME_CSUM_EN
   localparam int FRAME_BYTES = 9;
`else
   localparam int FRAME_BYTES = 8;
`endif

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_SEND    = 2'd2,
      ST_CSUM    = 2'd3
   } state_t;

   // Tagged payload byte idx of sample s (bit 0 of byte 0 is a fixed marker)
   function automatic logic [7:0] frame_byte(input logic [31:0] s, input logic [2:0] idx);
      logic [7:0] b;
      b = 8'h00;
      case (idx)
         3'd0:    b = {TAG_B0, s[3:0], 1'b1};
         3'd1:    b = {TAG_B1, s[8:4]};
         3'd2:    b = {TAG_B2, s[13:9]};
         3'd3:    b = {TAG_B3, s[18:14]};
         3'd4:    b = {TAG_B4, s[23:19]};
         3'd5:    b = {TAG_B5, s[28:24]};
         3'd6:    b = {TAG_B6, 2'b00, s[31:29]};
         default: b = {TAG_B7, 5'b00000};
      endcase
      return b;
   endfunction

   // XOR of the eight payload bytes of sample s
   function automatic logic [7:0] frame_csum(input logic [31:0] s);
      logic [7:0] c;
      c = 8'h00;
      for (int i = 0; i < 8; i++) begin
         c = c ^ frame_byte(s, 3'(i));
      end
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr32_step.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr32_step
//  Purpose  : 32-bit Fibonacci LFSR register with step enable and seed load.
//             A zero seed is replaced by RESET_VALUE so the LFSR never locks.
//  Revision : 1.0 - initial release
// ============================================================================
module lfsr32_step #(
   parameter logic [31:0] RESET_VALUE = 32'h0000_0001
) (
   input  logic        clk,
   input  logic        clr_n,
   input  logic        i_en,
   input  logic        i_load,
   input  logic [31:0] i_seed,
   output logic [31:0] o_q
);

   logic [31:0] r_q;
   logic        w_fb;

   assign w_fb = r_q[31] ^ r_q[21] ^ r_q[1] ^ r_q[0];
   assign o_q  = r_q;

   // Load has priority over stepping; shift right with feedback into bit 31
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_q <= RESET_VALUE;
      end else if (i_load) begin
         r_q <= (i_seed == 32'h0) ? RESET_VALUE : i_seed;
      end else if (i_en) begin
         r_q <= {w_fb, r_q[31:1]};
      end
   end

endmodule
`default_nettype wire

// File: rtl/lfsr_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_frame_ctrl
//  Purpose  : Snapshots and steps a 32-bit LFSR, packs each sample into a
//             tagged frame and streams it over a valid/ready byte interface.
//             Supports N-frame bursts, continuous runs and host seeding.
//  Config   : FRAME_CSUM_EN - appends a 9th byte, XOR of bytes 0..7
//  Revision : 1.0 - initial release
// ============================================================================
module lfsr_frame_ctrl #(
   parameter int          CNT_W    = 16,
   parameter logic [31:0] RST_SEED = 32'h0000_0001
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             start,
   input  logic             continuous,
   input  logic             stop,
   input  logic [CNT_W-1:0] count,
   input  logic             seed_load,
   input  logic [31:0]      seed,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic [31:0]      sample,
   output logic             busy,
   output logic             done
);

   import lfsr_pkg::*;

   localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   logic [2:0]       r_idx;
   logic [CNT_W-1:0] r_remaining;
   logic             r_cont;
   logic             r_stop_seen;
   logic [31:0]      r_sample;
   logic [7:0]       r_tx_data;
   logic             r_tx_valid;
   logic             r_busy;
   logic             r_done;

   logic [31:0]      w_q;
   logic             w_accept;
   logic             w_frame_end;
   logic             w_run_over;

   // The LFSR only advances while a sample is being captured; seeding is
   // an idle-only operation, so a same-cycle start sees the new seed first.
   lfsr32_step #(
      .RESET_VALUE (RST_SEED)
   ) u_lfsr (
      .clk    (clk),
      .clr_n  (clr_n),
      .i_en   (r_state == ST_CAPTURE),
      .i_load ((r_state == ST_IDLE) && seed_load),
      .i_seed (seed),
      .o_q    (w_q)
   );

   assign w_accept = r_tx_valid && tx_ready;

`ifdef FRAME_CSUM_EN
   assign w_frame_end = (r_state == ST_CSUM) && w_accept;
`else
   assign w_frame_end = (r_state == ST_SEND) && (r_idx == 3'd7) && w_accept;
`endif

   // End-of-run decision taken on the last byte's handshake; a stop arriving
   // on that very cycle still counts in continuous mode.
   assign w_run_over = r_cont ? (r_stop_seen || stop) : (r_remaining == c_cnt_one);

   // Sequencer FSM with registered stream outputs
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_state     <= ST_IDLE;
         r_idx       <= 3'd0;
         r_remaining <= '0;
         r_cont      <= 1'b0;
         r_stop_seen <= 1'b0;
         r_sample    <= 32'h0;
         r_tx_data   <= 8'h00;
         r_tx_valid  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;

         if (stop && r_cont && (r_state != ST_IDLE)) begin
            r_stop_seen <= 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state     <= ST_CAPTURE;
                  r_busy      <= 1'b1;
                  r_cont      <= continuous;
                  r_stop_seen <= 1'b0;
                  r_remaining <= (count == '0) ? c_cnt_one : count;
               end
            end
            ST_CAPTURE: begin
               r_sample   <= w_q;
               r_idx      <= 3'd0;
               r_tx_data  <= frame_byte(w_q, 3'd0);
               r_tx_valid <= 1'b1;
               r_state    <= ST_SEND;
            end
            ST_SEND: begin
               if (w_accept && (r_idx != 3'd7)) begin
                  r_idx     <= r_idx + 3'd1;
                  r_tx_data <= frame_byte(r_sample, r_idx + 3'd1);
               end
`ifdef FRAME_CSUM_EN
               else if (w_accept) begin
                  r_tx_data <= frame_csum(r_sample);
                  r_state   <= ST_CSUM;
               end
`endif
            end
            default: begin
            end
         endcase

         if (w_frame_end) begin
            r_tx_valid <= 1'b0;
            if (w_run_over) begin
               r_state     <= ST_IDLE;
               r_busy      <= 1'b0;
               r_done      <= 1'b1;
               r_stop_seen <= 1'b0;
            end else begin
               r_state <= ST_CAPTURE;
               if (!r_cont) begin
                  r_remaining <= r_remaining - c_cnt_one;
               end
            end
         end
      end
   end

   assign tx_data  = r_tx_data;
   assign tx_valid = r_tx_valid;
   assign sample   = r_sample;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lfsr_frame_ctrl
//  Purpose  : Self-checking bench for lfsr_frame_ctrl against a behavioural
//             model of the LFSR sequence and frame format.
//  Config   : FRAME_CSUM_EN - expects the 9-byte checksum frame
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_frame_ctrl;

`ifdef FRAME_CSUM_EN
   localparam int FB = 9;
`else
   localparam int FB = 8;
`endif

   logic        clk = 1'b0;
   logic        clr_n = 1'b0;
   logic        start = 1'b0;
   logic        continuous = 1'b0;
   logic        stop = 1'b0;
   logic [15:0] count = 16'd1;
   logic        seed_load = 1'b0;
   logic [31:0] seed = 32'h0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic [31:0] sample;
   logic        busy;
   logic        done;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] mq;          // model: next value the LFSR will hand out
   bit          tog = 1'b0;

   lfsr_frame_ctrl #(.CNT_W(16), .RST_SEED(32'h0000_0001)) dut (
      .clk        (clk),
      .clr_n      (clr_n),
      .start      (start),
      .continuous (continuous),
      .stop       (stop),
      .count      (count),
      .seed_load  (seed_load),
      .seed       (seed),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .sample     (sample),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: LFSR step as integer arithmetic on the tap positions
   function automatic logic [31:0] model_step(input logic [31:0] q);
      logic [31:0] fb;
      fb = ((q >> 31) ^ (q >> 21) ^ (q >> 1) ^ q) & 32'd1;
      return (q >> 1) | (fb << 31);
   endfunction

   // Reference: byte k (0..7) of the frame for sample s
   function automatic logic [7:0] model_byte(input logic [31:0] s, input int k);
      logic [31:0] v;
      if (k == 0)      v = ((s & 32'd15) << 1) | 32'd1;
      else if (k <= 5) v = (32'(k) << 5) | ((s >> (4 + 5 * (k - 1))) & 32'd31);
      else if (k == 6) v = (32'd6 << 5) | ((s >> 29) & 32'd7);
      else             v = 32'd7 << 5;
      return v[7:0];
   endfunction

   function automatic logic [7:0] model_csum(input logic [31:0] s);
      logic [7:0] c;
      c = 8'h00;
      for (int j = 0; j < 8; j++) c = c ^ model_byte(s, j);
      return c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Start a run and consume nfr frames. mode: 0 ready=1, 1 toggle, 2 random.
   // stop is pulsed at (stop_fr, stop_bi); poke issues start+seed_load mid-run.
   task automatic run(input logic [31:0] sd, input bit do_seed, input int cnt,
                      input bit cont, input int nfr, input int mode,
                      input int stop_fr, input int stop_bi, input bit poke);
      logic [31:0] s;
      logic [7:0]  exp_b;
      logic [7:0]  held;
      int          cyc;
      int          stalls;
      if (do_seed) begin
         seed_load = 1'b1;
         seed      = sd;
         mq        = (sd == 32'h0) ? 32'h1 : sd;
      end
      start      = 1'b1;
      continuous = cont;
      count      = 16'(cnt);
      tick();
      start     = 1'b0;
      seed_load = 1'b0;
      check("latency_busy", busy, 1);
      check("latency_capture_valid", tx_valid, 0);
      tick();
      for (int fr = 0; fr < nfr; fr++) begin
         s  = mq;
         mq = model_step(mq);
         for (int bi = 0; bi < FB; bi++) begin
            exp_b  = (bi < 8) ? model_byte(s, bi) : model_csum(s);
            cyc    = 0;
            stalls = 0;
            forever begin
               check("valid_in_frame", tx_valid, 1);
               case (mode)
                  0:       tx_ready = 1'b1;
                  1:       begin tog = ~tog; tx_ready = tog; end
                  default: tx_ready = (stalls >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
               endcase
               stop = (cyc == 0) && (fr == stop_fr) && (bi == stop_bi);
               if (poke && (fr == 0) && (bi == 2) && (cyc == 0)) begin
                  start     = 1'b1;
                  seed_load = 1'b1;
                  seed      = $urandom;
                  count     = 16'd5;
               end
               if (tx_valid && tx_ready) begin
                  check($sformatf("frame%0d_byte%0d", fr, bi), tx_data, exp_b);
                  tick();
                  stop = 1'b0; start = 1'b0; seed_load = 1'b0;
                  break;
               end
               held = tx_data;
               stalls++;
               tick();
               stop = 1'b0; start = 1'b0; seed_load = 1'b0;
               check("stall_hold", tx_data, held);
               cyc++;
               if (cyc > 64) begin
                  checks++;
                  errors++;
                  $error("FAIL handshake_budget frame=%0d byte=%0d waited=%0d limit=64", fr, bi, cyc);
                  return;
               end
            end
         end
         check("sample", sample, s);
         if (fr == nfr - 1) begin
            check("done_pulse", done, 1);
            check("busy_at_end", busy, 0);
            check("valid_at_end", tx_valid, 0);
            tick();
            check("done_once", done, 0);
         end else begin
            check("bubble_valid", tx_valid, 0);
            check("bubble_done", done, 0);
            tick();
         end
      end
      tx_ready = 1'b1;
   endtask

   initial begin
      mq = 32'h1;
      // Reset state
      #3;
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sample", sample, 0);
      @(negedge clk);
      clr_n = 1'b1;
      tick();

      // Single frame from reset seed
      run(32'h0, 1'b0, 1, 1'b0, 1, 0, -1, -1, 1'b0);
      check("seed1_sample_value", sample, 32'h0000_0001);

      // Seed and start together, two frames
      run(32'h1, 1'b1, 2, 1'b0, 2, 0, -1, -1, 1'b0);
      check("second_sample_value", sample, 32'h8000_0000);

      // Stalling sink, random seed
      run($urandom, 1'b1, 1, 1'b0, 1, 1, -1, -1, 1'b0);

      // Zero seed loaded alone, then start; start/seed_load while busy ignored
      seed_load = 1'b1;
      seed      = 32'h0;
      tick();
      seed_load = 1'b0;
      mq        = 32'h1;
      check("zero_seed_idle", busy, 0);
      run(32'h0, 1'b0, 3, 1'b0, 3, 1, -1, -1, 1'b1);

      // Continuous run, stop in the middle of the third frame
      run($urandom, 1'b1, 1, 1'b1, 3, 2, 2, 4, 1'b0);

      // Stop in burst mode is ignored; count 0 acts as 1
      run($urandom, 1'b1, 2, 1'b0, 2, 0, 0, 3, 1'b0);
      run($urandom, 1'b1, 0, 1'b0, 1, 2, -1, -1, 1'b0);

      // Randomised bursts
      for (int it = 0; it < 3; it++) begin
         int n;
         n = $urandom_range(1, 3);
         run($urandom, 1'b1, n, 1'b0, n, 2, -1, -1, 1'b0);
      end

      // Asynchronous reset while byte 4 is on the bus
      tx_ready   = 1'b1;
      continuous = 1'b0;
      count      = 16'd1;
      start      = 1'b1;
      tick();
      start = 1'b0;
      tick();
      for (int k = 0; k < 4; k++) tick();
      check("pre_reset_byte4", tx_data, model_byte(mq, 4));
      #2;
      clr_n = 1'b0;
      #1;
      check("areset_tx_valid", tx_valid, 0);
      check("areset_busy", busy, 0);
      check("areset_tx_data", tx_data, 0);
      check("areset_sample", sample, 0);
      @(negedge clk);
      clr_n = 1'b1;
      tick();
      mq = 32'h1;
      run(32'h0, 1'b0, 1, 1'b0, 1, 0, -1, -1, 1'b0);
      check("post_reset_sample", sample, 32'h0000_0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
